// File: rtl/mdu.sv
// RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide
// on operand magnitudes, with one-cycle fast paths for divide-by-zero and signed overflow.
module mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      wa,
    output logic            we
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              last_iter;

    logic [2:0]        f_q;
    logic [XLEN-1:0]   opd;
    logic [2*XLEN-1:0] acc;
    logic [4:0]        cnt;
    logic              fast;
    logic              neg_lo;
    logic              neg_hi;

    // Accept-time operand decode
    logic              is_div;
    logic              a_sgn;
    logic              b_sgn;
    logic              sa;
    logic              sb;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              div_zero;
    logic              ovf;
    logic [XLEN-1:0]   fast_res;

    // Iteration datapath
    logic [XLEN:0]     sum;
    logic [XLEN:0]     r;
    logic              ge;
    logic [XLEN-1:0]   rem_next;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   final_res;

    // A request is also taken in DONE so back-to-back operations issue every 33 cycles.
    assign accept    = start && (state == IDLE || state == DONE);
    assign last_iter = (cnt == 5'd31);

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign we   = done && (wa != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (fast || last_iter) state_next = DONE;
            DONE:    state_next = start ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        is_div   = funct3[2];
        a_sgn    = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
        b_sgn    = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
        sa       = a_sgn && a[XLEN-1];
        sb       = b_sgn && b[XLEN-1];
        mag_a    = sa ? XLEN'(0) - a : a;
        mag_b    = sb ? XLEN'(0) - b : b;
        div_zero = is_div && (b == '0);
        ovf      = is_div && !funct3[0] && (a == MIN_NEG) && (b == '1);
        if (funct3[1]) fast_res = div_zero ? a : '0;
        else           fast_res = div_zero ? '1 : MIN_NEG;
    end

    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
    always_comb begin
        sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : '0);
        r        = acc[2*XLEN-1:XLEN-1];
        ge       = (r >= {1'b0, opd});
        rem_next = ge ? XLEN'(r - {1'b0, opd}) : r[XLEN-1:0];
        if (f_q[2]) acc_step = {rem_next, acc[XLEN-2:0], ge};
        else        acc_step = {sum, acc[XLEN-1:1]};

        prod_fix = neg_lo ? (2*XLEN)'(0) - acc_step : acc_step;
        quo      = acc_step[XLEN-1:0];
        rem      = acc_step[2*XLEN-1:XLEN];
        if (!f_q[2])     final_res = (f_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        else if (f_q[1]) final_res = neg_hi ? XLEN'(0) - rem : rem;
        else             final_res = neg_lo ? XLEN'(0) - quo : quo;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_q    <= '0;
            opd    <= '0;
            acc    <= '0;
            cnt    <= '0;
            fast   <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            result <= '0;
            wa     <= '0;
        end else if (accept) begin
            f_q    <= funct3;
            wa     <= rd_in;
            cnt    <= '0;
            fast   <= div_zero || ovf;
            neg_lo <= sa ^ sb;
            neg_hi <= sa;
            if (div_zero || ovf) begin
                acc <= {{XLEN{1'b0}}, fast_res};
                opd <= mag_b;
            end else if (is_div) begin
                acc <= {{XLEN{1'b0}}, mag_a};
                opd <= mag_b;
            end else begin
                acc <= {{XLEN{1'b0}}, mag_b};
                opd <= mag_a;
            end
        end else if (state == CALC) begin
            if (fast) begin
                result <= acc[XLEN-1:0];
            end else begin
                acc <= acc_step;
                cnt <= cnt + 5'd1;
                if (last_iter) result <= final_res;
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: transaction-level reference model checked every cycle,
// plus directed vectors with hand-computed results and latencies.
module tb_mdu;

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  wa;
    logic        we;

    mdu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3), .a(a), .b(b), .rd_in(rd_in),
        .busy(busy), .done(done), .result(result), .wa(wa), .we(we)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Architectural result straight from the RV32M definitions.
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint ux = longint'({32'b0, x});
        longint uy = longint'({32'b0, y});
        logic [63:0] p;
        int ix = $signed(x);
        int iy = $signed(y);
        logic ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (f)
            F_MUL:    begin p = 64'(ux * uy); return p[31:0];  end
            F_MULH:   begin p = 64'(sx * sy); return p[63:32]; end
            F_MULHSU: begin p = 64'(sx * uy); return p[63:32]; end
            F_MULHU:  begin p = 64'(ux * uy); return p[63:32]; end
            F_DIV:    return (y == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ix / iy);
            F_DIVU:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
            F_REM:    return (y == 0) ? x : ovf ? 32'h0 : 32'(ix % iy);
            default:  return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        return f[2] && ((y == 0) || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    endfunction

    // Model: cycles of busy remaining; done is the last of them.
    int          m_left = 0;
    logic [31:0] m_res  = '0;
    logic [4:0]  m_wa   = '0;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
        end else if (m_left <= 1 && start) begin
            m_res  = ref_result(funct3, a, b);
            m_wa   = rd_in;
            m_left = is_fast(funct3, a, b) ? 2 : 33;
        end else if (m_left > 0) begin
            m_left--;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc busy", 32'(busy), 32'(m_left != 0));
            check("cyc done", 32'(done), 32'(m_left == 1));
            check("cyc we",   32'(we),   32'(m_left == 1 && m_wa != 0));
            if (m_left == 1) begin
                check("cyc result", result, m_res);
                check("cyc wa", 32'(wa), 32'(m_wa));
            end
        end
    end

    task automatic launch(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input logic [4:0] rd);
        @(negedge clk);
        rst = 1'b0; funct3 = f; a = x; b = y; rd_in = rd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic [31:0] exp, input int exp_lat, input int lat0,
                             input logic [4:0] exp_wa);
        int lat = lat0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " result"}, result, exp);
        check({name, " wa"}, 32'(wa), 32'(exp_wa));
        check({name, " we"}, 32'(we), 32'(exp_wa != 0));
        @(negedge clk);
        check({name, " busy after"}, 32'(busy), 32'(0));
    endtask

    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] rd, input logic [31:0] exp, input int exp_lat);
        launch(f, x, y, rd);
        wait_done(name, exp, exp_lat, 0, rd);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        rst = 1'b1; start = 1'b0; funct3 = '0; a = '0; b = '0; rd_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("reset busy",   32'(busy), 32'(0));
        check("reset done",   32'(done), 32'(0));
        check("reset we",     32'(we),   32'(0));
        check("reset result", result,    32'h0);
        check("reset wa",     32'(wa),   32'(0));

        // First accept on the very edge reset is released.
        run_op("mul 7x6",      F_MUL,    32'd7,          32'd6,          5'd3,  32'd42,         32);
        run_op("mul -3x5",     F_MUL,    32'hFFFF_FFFD,  32'd5,          5'd1,  32'hFFFF_FFF1,  32);
        run_op("mulh -1x-1",   F_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'h0000_0000,  32);
        run_op("mulhu max",    F_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFE,  32);
        run_op("mulhsu max",   F_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFF,  32);
        run_op("mulhu 2^31sq", F_MULHU,  32'h8000_0000,  32'h8000_0000,  5'd6,  32'h4000_0000,  32);
        run_op("div -7/2",     F_DIV,    32'hFFFF_FFF9,  32'd2,          5'd8,  32'hFFFF_FFFD,  32);
        run_op("rem -7%2",     F_REM,    32'hFFFF_FFF9,  32'd2,          5'd8,  32'hFFFF_FFFF,  32);
        run_op("divu 100/7",   F_DIVU,   32'd100,        32'd7,          5'd9,  32'd14,         32);
        run_op("remu 100%7",   F_REMU,   32'd100,        32'd7,          5'd9,  32'd2,          32);
        run_op("divu 5/0",     F_DIVU,   32'd5,          32'd0,          5'd10, 32'hFFFF_FFFF,  1);
        run_op("rem x%0",      F_REM,    32'h0000_1234,  32'd0,          5'd11, 32'h0000_1234,  1);
        run_op("div ovf",      F_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'h8000_0000,  1);
        run_op("rem ovf",      F_REM,    32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'h0,          1);
        run_op("mul rd0",      F_MUL,    32'd9,          32'd9,          5'd0,  32'd81,         32);

        // A second request at k+5 must be ignored.
        launch(F_MUL, 32'd5, 32'd9, 5'd7);
        repeat (4) @(negedge clk);
        funct3 = F_MUL; a = 32'd100; b = 32'd100; rd_in = 5'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 32'd1; b = 32'd1;
        wait_done("ignored start", 32'd45, 32, 5, 5'd7);

        // start held high: accepts at k, k+33, k+66 while operands keep changing.
        cnt = 0;
        @(negedge clk);
        funct3 = F_MUL; a = 32'd2; b = 32'd3; rd_in = 5'd1; start = 1'b1;
        for (int i = 0; i < 67; i++) begin
            @(negedge clk);
            if (done) cnt++;
            a = a + 32'(i * 3 + 1);
            b = b + 32'd5;
            rd_in = 5'(i + 2);
        end
        start = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("burst accepts", 32'(cnt), 32'd3);

        // Reset in the middle of a divide.
        launch(F_DIV, 32'd1000, 32'd7, 5'd4);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy",   32'(busy), 32'(0));
        check("midrst done",   32'(done), 32'(0));
        check("midrst result", result,    32'h0);
        check("midrst wa",     32'(wa),   32'(0));
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("midrst no done", 32'(cnt), 32'd0);
        run_op("mul 3x4", F_MUL, 32'd3, 32'd4, 5'd5, 32'd12, 32);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001: Parameter XLEN, default 32, operand and result width; only 32 is supported.
REQ-002: clk  input  1  sole clock; all state updates on rising edge.
REQ-003: rst  input  1  reset, synchronous, active-high.
REQ-004: start  input  1  request; sampled only in IDLE.
REQ-005: funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006: a  input  32  rs1 operand, driven from register file rd1.
REQ-007: b  input  32  rs2 operand, driven from register file rd2.
REQ-008: rd_in  input  5  destination register index.
REQ-009: busy  output  1  high in CALC and DONE.
REQ-010: done  output  1  single-cycle completion pulse.
REQ-011: result  output  32  32-bit result, feeds register file wd3.
REQ-012: wa  output  5  latched rd_in, feeds register file wa3.
REQ-013: we  output  1  write enable, feeds register file we3; we = done AND (wa != 0).

Function
REQ-014: FSM states IDLE, CALC and DONE; transitions IDLE->CALC on start, CALC->DONE after last iteration, DONE->IDLE unconditionally.
REQ-015: On accept (edge k, IDLE, start=1), a, b, funct3 and rd_in are latched; later input changes have no effect until the next accept.
REQ-016: Multiply uses 32-iteration shift-add on operand magnitudes; signedness follows funct3 (MULHSU: a signed, b unsigned); the 64-bit product is sign-corrected at the end.
REQ-017: MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
REQ-018: Divide uses 32-iteration restoring division on magnitudes; quotient sign = sign(a) XOR sign(b), remainder sign = sign(a), for signed ops only.
REQ-019: Normal-path latency: iterations at edges k+1..k+32; DONE entered at edge k+32; done=1 for exactly the cycle after edge k+32; IDLE again at edge k+33.
REQ-020: Divide by zero (b=0) is a fast path: DONE at edge k+1; DIV/DIVU return 0xFFFFFFFF; REM/REMU return a.
REQ-021: Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF) is a fast path: DONE at edge k+1; DIV returns 0x80000000; REM returns 0.
REQ-022: start while busy is ignored; no queuing.
REQ-023: start is accepted in the same cycle the FSM returns to IDLE (back-to-back: next accept at edge k+33 at the earliest).
REQ-024: result and wa hold their last values from DONE until the next completion; result is only valid while done=1.
REQ-025: rd_in=0 runs a full computation with we held at 0.

Reset
REQ-026: rst=1 at any edge, including mid-CALC, forces IDLE and sets busy=0, done=0, we=0, result=0, wa=0, and clears the internal accumulator, counter and latches; rst has priority over start.
REQ-027: The first accept after reset release is possible on the edge where rst=0.

Verification
REQ-028: MUL a=7, b=6, rd_in=3 -> done at the cycle after edge k+32; result=42; wa=3; we=1 for one cycle; busy low at edge k+33.
REQ-029: MULH a=0xFFFFFFFF, b=0xFFFFFFFF -> 0x00000000; MULHU with same operands -> 0xFFFFFFFE; MULHSU with same operands -> 0xFFFFFFFF.
REQ-030: DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD; REM with same operands -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14; REMU with same operands -> 2.
REQ-031: DIVU a=5, b=0 -> done at the cycle after edge k+1, result=0xFFFFFFFF; DIV a=0x80000000, b=-1 -> done after k+1, result 0x80000000.
REQ-032: start held high continuously with changing operands -> exactly one accept per 33 cycles; a second start at k+5 is ignored and the results match the latched operands.
REQ-033: rst pulsed at k+10 of a DIV -> busy=0, done never pulses, result=0; a new MUL 3x4 afterwards returns 12.
